// File: rtl/rotor2_fwd_stage_if.sv
// rotor2_fwd_stage_if
//   Bundles the stepping controls, letter path and position export of the
//   rotor 2 forward stage.
//   master : drives load/step controls and the entry letter (rotor 1 side)
//   slave  : the rotor stage; returns exit letter, live position and carry
interface rotor2_fwd_stage_if;
    logic       load_en;
    logic [4:0] load_pos;
    logic       key_step;
    logic       step_in;
    logic       in_valid;
    logic [4:0] in;
    logic       out_valid;
    logic [4:0] out;
    logic [4:0] rotate;
    logic       step_out;

    modport master (
        output load_en, load_pos, key_step, step_in, in_valid, in,
        input  out_valid, out, rotate, step_out
    );

    modport slave (
        input  load_en, load_pos, key_step, step_in, in_valid, in,
        output out_valid, out, rotate, step_out
    );
endinterface

// File: rtl/rotor2_fwd_stage.sv
// rotor2_fwd_stage
//   Forward path of rotor 2 plus its position register and stepping logic.
//   The entry letter is passed through the rotor II wiring and offset by the
//   current position. The position advances on key_step when rotor 1 carries,
//   or on its own while sitting at NOTCH (double-step), and a registered carry
//   pulse is sent to rotor 3 whenever the rotor leaves NOTCH.
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : rotor2_fwd_stage_if.slave
//            in  : load_en, load_pos[4:0], key_step, step_in, in_valid, in[4:0]
//            out : out_valid, out[4:0] (0 = illegal entry), rotate[4:0], step_out
module rotor2_fwd_stage #(
    parameter int NOTCH       = 4,
    parameter bit DOUBLE_STEP = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    rotor2_fwd_stage_if.slave bus
);

    logic [4:0] pos;
    logic [4:0] out_q;
    logic       out_valid_q;
    logic       step_out_q;

    logic       at_notch;
    logic       adv;
    logic       legal;
    logic [4:0] wired;
    logic [5:0] sum;
    logic [4:0] letter;

    function automatic logic [4:0] wiring(input logic [4:0] idx);
        logic [4:0] w;
        w = 5'd0;
        case (idx)
            5'd1:  w = 5'd6;
            5'd2:  w = 5'd15;
            5'd3:  w = 5'd11;
            5'd4:  w = 5'd21;
            5'd5:  w = 5'd4;
            5'd6:  w = 5'd1;
            5'd7:  w = 5'd26;
            5'd8:  w = 5'd14;
            5'd9:  w = 5'd17;
            5'd10: w = 5'd16;
            5'd11: w = 5'd24;
            5'd12: w = 5'd23;
            5'd13: w = 5'd2;
            5'd14: w = 5'd10;
            5'd15: w = 5'd9;
            5'd16: w = 5'd5;
            5'd17: w = 5'd8;
            5'd18: w = 5'd3;
            5'd19: w = 5'd13;
            5'd20: w = 5'd19;
            5'd21: w = 5'd7;
            5'd22: w = 5'd12;
            5'd23: w = 5'd18;
            5'd24: w = 5'd25;
            5'd25: w = 5'd20;
            5'd26: w = 5'd22;
            default: w = 5'd0;
        endcase
        return w;
    endfunction

    assign at_notch = (pos == 5'(NOTCH));
    assign adv      = bus.key_step & (bus.step_in | (DOUBLE_STEP & at_notch));

    // Letter path always uses the position held before this edge, so a letter
    // arriving together with a step or a load enciphers at the old position.
    always_comb begin
        legal  = (bus.in != 5'd0) && (bus.in <= 5'd26);
        wired  = wiring(bus.in);
        sum    = {1'b0, wired} + {1'b0, pos};
        letter = 5'd0;
        if (legal) begin
            // A residue of 0 is represented as 26, so only strictly >26 wraps.
            letter = (sum > 6'd26) ? 5'(sum - 6'd26) : 5'(sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos         <= 5'd0;
            out_q       <= 5'd0;
            out_valid_q <= 1'b0;
            step_out_q  <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q <= letter;
            end

            if (bus.load_en) begin
                // Out-of-range load values are dropped rather than clamped.
                if (bus.load_pos <= 5'd25) begin
                    pos <= bus.load_pos;
                end
                step_out_q <= 1'b0;
            end else if (adv) begin
                pos        <= (pos == 5'd25) ? 5'd0 : pos + 5'd1;
                step_out_q <= at_notch;
            end else begin
                step_out_q <= 1'b0;
            end
        end
    end

    assign bus.rotate    = pos;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.step_out  = step_out_q;

endmodule
